// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter and block-fill sequencer.
package mem_arb_pkg;

  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned WPB            = 8;
  localparam int unsigned IDX_W          = 3;
  localparam int unsigned BLOCK_OFF_BITS = 4;
  localparam int unsigned WORD_BYTES     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Block-aligned base of a byte address.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:BLOCK_OFF_BITS], BLOCK_OFF_BITS'(0)};
  endfunction

endpackage

// File: rtl/mem_fill_seq.sv
// Block-fill sequencer: issue/receive counters, completion flags and base+2k
// address generation for one WPB-word fill.
module mem_fill_seq
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              issuing,
  input  logic              receiving,
  input  logic              mem_data_valid,
  output logic [ADDR_W-1:0] issue_addr_c,
  output logic              issue_last_c,
  output logic              recv_fire_c,
  output logic              recv_last_c,
  output logic [IDX_W-1:0]  recv_idx
);

  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  issue_cnt_q;

  // Returns outside ISSUE/DRAIN are dropped here, so stale data never reaches a cache.
  assign recv_fire_c  = receiving && mem_data_valid;
  assign issue_last_c = issuing && (issue_cnt_q == IDX_W'(WPB - 1));
  assign recv_last_c  = recv_fire_c && (recv_idx == IDX_W'(WPB - 1));
  assign issue_addr_c = ADDR_W'(base_q + ADDR_W'(ADDR_W'(issue_cnt_q) * ADDR_W'(WORD_BYTES)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_idx    <= '0;
    end else if (start) begin
      base_q      <= block_base(start_addr);
      issue_cnt_q <= '0;
      recv_idx    <= '0;
    end else begin
      if (issuing)     issue_cnt_q <= issue_cnt_q + 1'b1;
      if (recv_fire_c) recv_idx    <= recv_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arb_fill.sv
// Shared main-memory arbiter: write-through first, then alternating I/D block
// fills streamed back into the owning cache.
module mem_arb_fill
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_word_idx,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              busy
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, last_owner_q;
  logic              start_c;
  logic [ADDR_W-1:0] start_addr_c;
  logic [ADDR_W-1:0] issue_addr_c;
  logic              issue_last_c, recv_fire_c, recv_last_c;
  logic [IDX_W-1:0]  recv_idx;
  logic              issuing_c, receiving_c;

  assign issuing_c   = (state_q == ST_ISSUE);
  assign receiving_c = issuing_c || (state_q == ST_DRAIN);

  mem_fill_seq u_fill_seq (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start_c),
    .start_addr     (start_addr_c),
    .issuing        (issuing_c),
    .receiving      (receiving_c),
    .mem_data_valid (mem_data_valid),
    .issue_addr_c   (issue_addr_c),
    .issue_last_c   (issue_last_c),
    .recv_fire_c    (recv_fire_c),
    .recv_last_c    (recv_last_c),
    .recv_idx       (recv_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (recv_last_c) last_owner_q <= owner_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    start_c       = 1'b0;
    start_addr_c  = i_miss_addr;
    d_wr_ack      = 1'b0;
    mem_addr      = '0;
    mem_data_in   = '0;
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;
    fill_data     = '0;
    fill_word_idx = '0;
    i_fill_we     = 1'b0;
    d_fill_we     = 1'b0;
    i_fill_done   = 1'b0;
    d_fill_done   = 1'b0;
    busy          = (state_q != ST_IDLE);

    case (state_q)
      // Write-through wins; with both misses pending, serve whoever did not go last.
      ST_IDLE: begin
        if (d_wr_req) begin
          state_d = ST_WRITE;
        end else if (d_miss && (!i_miss || last_owner_q == OWN_I)) begin
          state_d      = ST_ISSUE;
          owner_d      = OWN_D;
          start_c      = 1'b1;
          start_addr_c = d_miss_addr;
        end else if (i_miss) begin
          state_d      = ST_ISSUE;
          owner_d      = OWN_I;
          start_c      = 1'b1;
          start_addr_c = i_miss_addr;
        end
      end
      ST_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_ISSUE: begin
        mem_enable = 1'b1;
        mem_addr   = issue_addr_c;
        if (issue_last_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase

    if (recv_fire_c) begin
      fill_data     = mem_data_out;
      fill_word_idx = recv_idx;
      i_fill_we     = (owner_q == OWN_I);
      d_fill_we     = (owner_q == OWN_D);
    end
    // Last word may land while still issuing if memory answers early.
    if (recv_last_c) begin
      i_fill_done = (owner_q == OWN_I);
      d_fill_done = (owner_q == OWN_D);
      state_d     = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_mem_arb_fill.sv
// Directed bench for mem_arb_fill against a 4-cycle pipelined memory model.
`timescale 1ns/1ps
module tb_mem_arb_fill;

  localparam int unsigned LAT   = 4;
  localparam logic [15:0] DMASK = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
  logic        d_wr_ack, mem_enable, mem_wr, mem_data_valid;
  logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
  logic [2:0]  fill_word_idx;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;
  logic        inj_valid = 1'b0;

  mem_arb_fill dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_word_idx(fill_word_idx),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic own; int idx; logic [15:0] data; int cyc; } fill_t;
  typedef struct { logic [15:0] addr; int cyc; } iss_t;
  typedef struct { logic own; int cyc; int n_own; int n_oth; } done_t;

  fill_t fill_q[$];
  iss_t  iss_q[$];
  iss_t  wr_q[$];
  done_t done_q[$];
  fill_t fe;
  iss_t  ie;
  done_t de;

  int ncyc, op_i, op_d, n_ack, ack_cyc, busy_fall, n_busy_rise, n_dn_i, n_dn_d;
  int n_checks, n_errors, g;
  logic        prev_busy = 1'b0;
  logic [15:0] wr_data_seen = '0;
  logic        req_v = 1'b0;
  logic [15:0] req_a = '0;

  // Memory: a read issued in cycle c returns in cycle c+LAT with data addr^DMASK.
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pa [LAT] = '{default: '0};

  always begin
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = req_v;
    pa[0] = req_a;
  end

  assign mem_data_valid = pv[LAT-1] | inj_valid;
  assign mem_data_out   = inj_valid ? 16'hDEAD : (pa[LAT-1] ^ DMASK);

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    ncyc++;
    req_v = mem_enable && !mem_wr;
    req_a = mem_addr;
    if (req_v) begin
      ie.addr = mem_addr; ie.cyc = ncyc; iss_q.push_back(ie);
    end
    if (mem_enable && mem_wr) begin
      ie.addr = mem_addr; ie.cyc = ncyc; wr_q.push_back(ie);
      wr_data_seen = mem_data_in;
    end
    if (d_wr_ack) begin
      n_ack++; ack_cyc = ncyc;
    end
    if (i_fill_we) begin
      fe.own = 1'b0; fe.idx = int'(fill_word_idx); fe.data = fill_data; fe.cyc = ncyc;
      fill_q.push_back(fe); op_i++;
    end
    if (d_fill_we) begin
      fe.own = 1'b1; fe.idx = int'(fill_word_idx); fe.data = fill_data; fe.cyc = ncyc;
      fill_q.push_back(fe); op_d++;
    end
    if (i_fill_done) begin
      de.own = 1'b0; de.cyc = ncyc; de.n_own = op_i; de.n_oth = op_d;
      done_q.push_back(de); n_dn_i++; op_i = 0; op_d = 0;
    end
    if (d_fill_done) begin
      de.own = 1'b1; de.cyc = ncyc; de.n_own = op_d; de.n_oth = op_i;
      done_q.push_back(de); n_dn_d++; op_i = 0; op_d = 0;
    end
    if (prev_busy && !busy) busy_fall = ncyc;
    if (!prev_busy && busy) n_busy_rise++;
    prev_busy = busy;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    fill_q.delete(); iss_q.delete(); wr_q.delete(); done_q.delete();
    op_i = 0; op_d = 0; n_ack = 0; ack_cyc = -1; busy_fall = -1;
    n_busy_rise = 0; n_dn_i = 0; n_dn_d = 0;
  endtask

  // Hold requests until their owner's done, drop the write after its ack.
  task automatic run_ops(input string tag, input int want_i, input int want_d, input int maxcyc);
    int c = 0;
    while ((n_dn_i < want_i || n_dn_d < want_d) && c < maxcyc) begin
      step(1);
      c++;
      if (d_wr_ack) d_wr_req = 1'b0;
      if (n_dn_i >= want_i) i_miss = 1'b0;
      if (n_dn_d >= want_d) d_miss = 1'b0;
    end
    chk_eq({tag, "_dones"}, 32'(n_dn_i + n_dn_d), 32'(want_i + want_d));
  endtask

  function automatic logic [15:0] exp_data(input logic [15:0] base, input int j);
    logic [15:0] a;
    a = base + 16'(2 * j);
    return a ^ DMASK;
  endfunction

  task automatic check_op(input string tag, input int f0, input logic own,
                          input logic [15:0] base, input int c0);
    chk_eq({tag, "_nfill"}, 32'(fill_q.size() >= f0 + 8), 32'(1));
    if (fill_q.size() >= f0 + 8) begin
      for (int j = 0; j < 8; j++) begin
        chk_eq({tag, "_idx"},  32'(fill_q[f0+j].idx), 32'(j));
        chk_eq({tag, "_own"},  32'(fill_q[f0+j].own), 32'(own));
        chk_eq({tag, "_data"}, 32'(fill_q[f0+j].data), 32'(exp_data(base, j)));
        chk_eq({tag, "_fcyc"}, 32'(fill_q[f0+j].cyc), 32'(c0 + j));
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    chk_eq({tag, "_ctl"}, 32'({busy, mem_enable, mem_wr, d_wr_ack,
                               i_fill_we, d_fill_we, i_fill_done, d_fill_done}), 32'(0));
    chk_eq({tag, "_bus"}, {mem_addr, mem_data_in}, 32'(0));
    chk_eq({tag, "_fill"}, {13'h0, fill_word_idx, fill_data}, 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    step(3);
    check_quiet("rst");
    rst_n = 1'b1;
    step(2);
    check_quiet("idle");

    // S1: single I miss, offset ignored, cycle-exact latency
    clear_logs();
    i_miss_addr = 16'h1236; i_miss = 1'b1; g = ncyc + 1;
    run_ops("s1", 1, 0, 40);
    step(2);
    chk_eq("s1_niss", 32'(iss_q.size()), 32'(8));
    for (int k = 0; k < 8 && k < iss_q.size(); k++) begin
      chk_eq("s1_addr", 32'(iss_q[k].addr), 32'(16'h1230 + 2 * k));
      chk_eq("s1_icyc", 32'(iss_q[k].cyc), 32'(g + 1 + k));
    end
    check_op("s1", 0, 1'b0, 16'h1230, g + 5);
    chk_eq("s1_ndone", 32'(done_q.size()), 32'(1));
    if (done_q.size() >= 1) begin
      chk_eq("s1_done_cyc", 32'(done_q[0].cyc), 32'(g + 12));
      chk_eq("s1_done_own", 32'(done_q[0].own), 32'(0));
    end
    chk_eq("s1_busy_fall", 32'(busy_fall), 32'(g + 13));

    // S2: write + D miss + I miss together
    clear_logs();
    d_wr_addr = 16'h2000; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
    d_miss_addr = 16'h3008; d_miss = 1'b1;
    i_miss_addr = 16'h400E; i_miss = 1'b1;
    g = ncyc + 1;
    run_ops("s2", 1, 1, 80);
    step(2);
    chk_eq("s2_nwr", 32'(wr_q.size()), 32'(1));
    if (wr_q.size() >= 1) begin
      chk_eq("s2_wr_addr", 32'(wr_q[0].addr), 32'(16'h2000));
      chk_eq("s2_wr_cyc", 32'(wr_q[0].cyc), 32'(g + 1));
    end
    chk_eq("s2_wr_data", 32'(wr_data_seen), 32'(16'hBEEF));
    chk_eq("s2_nack", 32'(n_ack), 32'(1));
    chk_eq("s2_ack_cyc", 32'(ack_cyc), 32'(g + 1));
    chk_eq("s2_niss", 32'(iss_q.size()), 32'(16));
    if (iss_q.size() >= 16) begin
      chk_eq("s2_d_base", 32'(iss_q[0].addr), 32'(16'h3000));
      chk_eq("s2_d_start", 32'(iss_q[0].cyc), 32'(g + 3));
      chk_eq("s2_i_base", 32'(iss_q[8].addr), 32'(16'h4000));
      chk_eq("s2_i_start", 32'(iss_q[8].cyc), 32'(g + 16));
    end
    chk_eq("s2_ndone", 32'(done_q.size()), 32'(2));
    if (done_q.size() >= 2) begin
      chk_eq("s2_own0", 32'(done_q[0].own), 32'(1));
      chk_eq("s2_own1", 32'(done_q[1].own), 32'(0));
      chk_eq("s2_cyc0", 32'(done_q[0].cyc), 32'(g + 14));
      chk_eq("s2_cyc1", 32'(done_q[1].cyc), 32'(g + 27));
      chk_eq("s2_n_own0", 32'(done_q[0].n_own), 32'(8));
      chk_eq("s2_n_oth0", 32'(done_q[0].n_oth), 32'(0));
      chk_eq("s2_n_own1", 32'(done_q[1].n_own), 32'(8));
      chk_eq("s2_n_oth1", 32'(done_q[1].n_oth), 32'(0));
    end
    check_op("s2d", 0, 1'b1, 16'h3000, g + 7);
    check_op("s2i", 8, 1'b0, 16'h4000, g + 20);

    // S3: both misses held, alternating D,I,D,I
    clear_logs();
    i_miss_addr = 16'h5000; d_miss_addr = 16'h6002;
    i_miss = 1'b1; d_miss = 1'b1; g = ncyc + 1;
    run_ops("s3", 2, 2, 120);
    step(2);
    chk_eq("s3_ndone", 32'(done_q.size()), 32'(4));
    chk_eq("s3_niss", 32'(iss_q.size()), 32'(32));
    for (int n = 0; n < 4 && n < done_q.size() && 8 * n < iss_q.size(); n++) begin
      chk_eq("s3_own", 32'(done_q[n].own), 32'((n % 2) == 0));
      chk_eq("s3_n_own", 32'(done_q[n].n_own), 32'(8));
      chk_eq("s3_n_oth", 32'(done_q[n].n_oth), 32'(0));
      chk_eq("s3_done_cyc", 32'(done_q[n].cyc), 32'(g + 12 + 13 * n));
      chk_eq("s3_start", 32'(iss_q[8*n].cyc), 32'(g + 1 + 13 * n));
      chk_eq("s3_base", 32'(iss_q[8*n].addr), ((n % 2) == 0) ? 32'(16'h6000) : 32'(16'h5000));
      check_op("s3", 8 * n, ((n % 2) == 0), ((n % 2) == 0) ? 16'h6000 : 16'h5000,
               g + 5 + 13 * n);
    end

    // S4: top-of-memory block, d_miss dropped mid-fill
    clear_logs();
    d_miss_addr = 16'hFFF4; d_miss = 1'b1; g = ncyc + 1;
    for (int c = 0; c < 10 && iss_q.size() < 2; c++) step(1);
    d_miss = 1'b0;
    run_ops("s4", 0, 1, 40);
    step(3);
    chk_eq("s4_niss", 32'(iss_q.size()), 32'(8));
    for (int k = 0; k < iss_q.size(); k++) begin
      chk_eq("s4_addr", 32'(iss_q[k].addr), 32'(16'hFFF0 + 2 * k));
    end
    check_op("s4", 0, 1'b1, 16'hFFF0, g + 5);
    if (done_q.size() >= 1) begin
      chk_eq("s4_own", 32'(done_q[0].own), 32'(1));
      chk_eq("s4_n_own", 32'(done_q[0].n_own), 32'(8));
    end

    // S5: async reset in the 3rd ISSUE cycle, stale and spurious returns ignored
    clear_logs();
    i_miss_addr = 16'h7000; i_miss = 1'b1; g = ncyc + 1;
    step(3);
    chk_eq("s5_pre_en", 32'(mem_enable), 32'(1));
    chk_eq("s5_pre_addr", 32'(mem_addr), 32'(16'h7004));
    rst_n = 1'b0; i_miss = 1'b0;
    #1;
    check_quiet("s5_rst");
    clear_logs();
    step(2);
    rst_n = 1'b1;
    step(1);
    inj_valid = 1'b1;
    step(1);
    inj_valid = 1'b0;
    step(1);
    inj_valid = 1'b1;
    step(1);
    inj_valid = 1'b0;
    step(3);
    chk_eq("s5_nfill", 32'(fill_q.size()), 32'(0));
    chk_eq("s5_ndone", 32'(done_q.size()), 32'(0));
    chk_eq("s5_niss", 32'(iss_q.size()), 32'(0));
    chk_eq("s5_busy_rise", 32'(n_busy_rise), 32'(0));
    clear_logs();
    i_miss = 1'b1; g = ncyc + 1;
    run_ops("s5b", 1, 0, 40);
    step(2);
    chk_eq("s5b_niss", 32'(iss_q.size()), 32'(8));
    if (iss_q.size() >= 1) chk_eq("s5b_base", 32'(iss_q[0].addr), 32'(16'h7000));
    check_op("s5b", 0, 1'b0, 16'h7000, g + 5);

    // S6: valid pulse in a normal IDLE, then a fresh D fill
    clear_logs();
    inj_valid = 1'b1;
    #1;
    chk_eq("s6_we", 32'({i_fill_we, d_fill_we}), 32'(0));
    step(1);
    inj_valid = 1'b0;
    step(2);
    chk_eq("s6_nfill", 32'(fill_q.size()), 32'(0));
    chk_eq("s6_busy_rise", 32'(n_busy_rise), 32'(0));
    d_miss_addr = 16'h0A1C; d_miss = 1'b1; g = ncyc + 1;
    run_ops("s6", 0, 1, 40);
    step(2);
    check_op("s6", 0, 1'b1, 16'h0A10, g + 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arb_fill.md
Name: mem_arb_fill

Overview:
- Sequences a single shared multi-cycle main memory, the unified backing store behind the I-cache and D-cache.
- Arbitrates between three requesters: I-cache miss, D-cache miss, and D-cache write-through.
- For a miss, issues a full block fill of WPB words and streams the returned words into the owning cache.
- Sits between both caches and the memory model. The CPU stalls while the relevant cache reports a miss.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, memory word width (2 bytes per word).
- WPB, 8, words per cache block (16-byte blocks).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- i_miss  in  1  I-cache miss request, level, held until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache miss byte address
- d_miss  in  1  D-cache miss request, level, held until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache miss byte address
- d_wr_req  in  1  D-cache write-through request, level, held until d_wr_ack
- d_wr_addr  in  ADDR_W  write byte address
- d_wr_data  in  DATA_W  write data
- d_wr_ack  out  1  one-cycle pulse in the cycle the write is issued
- mem_addr  out  ADDR_W  memory byte address
- mem_data_in  out  DATA_W  memory write data
- mem_enable  out  1  memory access strobe
- mem_wr  out  1  memory write strobe
- mem_data_out  in  DATA_W  memory read data
- mem_data_valid  in  1  read data valid, one per issued read, in issue order
- fill_data  out  DATA_W  returned word, equal to mem_data_out
- fill_word_idx  out  3  block offset of fill_data
- i_fill_we  out  1  write strobe into the I-cache data array
- d_fill_we  out  1  write strobe into the D-cache data array
- i_fill_done  out  1  one-cycle pulse on the last I word
- d_fill_done  out  1  one-cycle pulse on the last D word
- busy  out  1  FSM not in IDLE

Behaviour:
- States are IDLE, WRITE, ISSUE and DRAIN. On reset all outputs are 0, the state is IDLE, the counters are 0 and last_owner is I.
- Grant happens in IDLE only. Priority:
  - d_wr_req wins first.
  - Otherwise a single pending miss is granted.
  - If both misses are pending, grant the owner not equal to last_owner (alternating).
- Grant latches owner and base = addr with bits [3:0] cleared. Offset bits of the miss address are ignored.
- Requests are sampled only in IDLE. A requester dropping its request mid-operation does not abort; the operation completes.
- WRITE lasts 1 cycle:
  - mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data.
  - d_wr_ack=1 in the same cycle.
  - Next state IDLE.
- ISSUE lasts WPB cycles, with issue counter k = 0..7:
  - mem_enable=1, mem_wr=0, mem_addr=base+2k.
  - After k=7 go to DRAIN.
  - The receive logic runs in parallel with issue.
- Receive, in ISSUE or DRAIN:
  - Each mem_data_valid writes fill_data=mem_data_out with fill_word_idx = receive counter r.
  - Assert the owner's fill_we, then increment r.
  - When r=7 is written, pulse the owner's done in the same cycle, set last_owner=owner, and go to IDLE.
  - This transition can occur directly from ISSUE if memory returns data early.
- mem_data_valid in IDLE or WRITE is ignored, with no fill_we.
- No new grant occurs in the cycle a done pulse is issued; arbitration resumes the following cycle. Back-to-back operations therefore have 1 IDLE cycle between them.
- Address arithmetic is modulo 2^ADDR_W. A block at 0xFFF0 issues addresses up to 0xFFFE with no wrap into bit 16.
- Latency with a 4-cycle memory, first issue at cycle 0:
  - word k returns at cycle k+4;
  - done pulses at cycle 11;
  - grant-to-done is 12 cycles.
- Asynchronous reset mid-operation forces IDLE immediately and clears all outputs. In-flight memory returns after reset are ignored.
- mem_enable=0 and mem_wr=0 in IDLE and DRAIN.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding (IDLE/WRITE/ISSUE/DRAIN);
  - owner encoding (OWN_I=0, OWN_D=1);
  - constants BLOCK_OFF_BITS=4 and WORD_BYTES=2.
- Sub-module mem_fill_seq contains:
  - the issue counter and receive counter;
  - issue/drain completion flags;
  - base+2k address generation.
- The top level holds the arbitration, owner/last_owner and output muxing.

Test Plan:
- Reset, then i_miss=1 with i_miss_addr=0x1236 on a 4-cycle memory:
  - mem_addr=0x1230,0x1232,…,0x123E on 8 consecutive cycles;
  - i_fill_we with idx 0..7 at issue+4;
  - i_fill_done at cycle 11;
  - busy falls the next cycle.
- d_wr_req and d_miss and i_miss asserted together in IDLE:
  - WRITE first, with mem_wr=1 for 1 cycle and d_wr_ack;
  - then the D fill (last_owner=I), then the I fill;
  - no D strobes during the I fill.
- i_miss and d_miss held continuously: grants alternate D,I,D,I, and each done pulse belongs to the granted owner.
- d_miss_addr=0xFFF4: issued addresses are 0xFFF0..0xFFFE, the fill completes, and no address exceeds 0xFFFE.
- Assert rst_n=0 at the 3rd ISSUE cycle:
  - all outputs go to 0 immediately;
  - spurious mem_data_valid pulses after reset produce no fill_we;
  - the next i_miss restarts from idx 0.
- mem_data_valid pulsed while IDLE: no fill_we and no state change. A requester dropping d_miss mid-fill still receives 8 d_fill_we and d_fill_done.
